// File: rtl/fir_pkg.sv
// Shared constants for the 16-tap fixed-coefficient FIR path and its inverse.
// The forward filter and the recovering deconvolver both take their coefficients
// from FIR_COEFF, so the two ends of the link cannot drift apart.
package fir_pkg;

    localparam int NTAPS    = 16;
    localparam int COEFF_W  = 5;
    localparam int HIST_LEN = NTAPS - 1;
    localparam int IDX_W    = 4;

    typedef logic [COEFF_W-1:0] coeff_t;

    // b_k = k+1; b0 = 1 is what makes the all-pole inverse exact
    localparam coeff_t FIR_COEFF [0:NTAPS-1] = '{
        5'd1,  5'd2,  5'd3,  5'd4,  5'd5,  5'd6,  5'd7,  5'd8,
        5'd9,  5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // coefficient applied to history entry h[idx] is b_(idx+1)
    function automatic coeff_t hist_coeff(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] k;
        k = idx + 4'd1;
        return FIR_COEFF[k];
    endfunction

endpackage

// File: rtl/fir_inv_hist.sv
// History of recovered samples for fir_inverse: DEPTH x WIDTH shift register,
// h[0] newest. One shift per recovered sample; flush zeroes every entry.
// The tap output is a plain mux on a registered index so the downstream
// multiply sees a short path.
module fir_inv_hist
    import fir_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = HIST_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] tap
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [WIDTH-1:0] h [0:DEPTH-1];

    // shift register with synchronous flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                h[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                h[i] <= '0;
            end
        end else if (shift_en) begin
            h[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                h[i] <= h[i-1];
            end
        end
    end

    // selected tap; out-of-range index reads as zero
    always_comb begin
        tap = '0;
        if (rd_idx <= LAST_IDX) begin
            tap = h[rd_idx];
        end
    end

endmodule

// File: rtl/fir_inverse.sv
// Recovering deconvolver for the 16-tap FIR path.
// Takes y[n] (2*WIDTH bits) and rebuilds x[n] = y[n] - sum_{k=1..15} b_k*x[n-k]
// with a single time-multiplexed multiply-subtract, modulo 2^(2*WIDTH).
// Optional feature macro: FIR_INV_RANGE_CHK_EN adds o_range_err, flagging a
// residual that does not fit in WIDTH bits.
//
// state | meaning
// IDLE  | o_ready high, waiting for a y sample
// MAC   | one subtract of b_k*h[k-1] per cycle, k = 1..15
// OUT   | recovered sample presented, waiting for i_ready
module fir_inverse
    import fir_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*WIDTH-1:0] i_signal,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [WIDTH-1:0]   o_signal,
    output logic               o_valid,
    input  logic               i_ready,
    input  logic               i_flush
`ifdef FIR_INV_RANGE_CHK_EN
    ,
    output logic               o_range_err
`endif
);

    localparam int AW = 2 * WIDTH;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HIST_LEN - 1);

    fir_state_e       state;
    logic [AW-1:0]    acc;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] tap;
    coeff_t           coeff;
    logic [AW-1:0]    prod;
    logic [AW-1:0]    acc_next;
    logic             last_mac;
    logic             hist_shift;

    // constant multiplier fed by the registered history index
    always_comb begin
        coeff    = hist_coeff(idx);
        prod     = {{WIDTH{1'b0}}, tap} * {{(AW-COEFF_W){1'b0}}, coeff};
        acc_next = acc - prod;
        last_mac = (state == MAC) && (idx == LAST_IDX);
    end

    // history advances once per recovered sample, even if downstream stalls
    assign hist_shift = last_mac && !i_flush;
    assign o_ready    = (state == IDLE);

    fir_inv_hist #(
        .WIDTH (WIDTH),
        .DEPTH (HIST_LEN)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (i_flush),
        .shift_en (hist_shift),
        .din      (acc_next[WIDTH-1:0]),
        .rd_idx   (idx),
        .tap      (tap)
    );

    // sequencing FSM with registered outputs; flush wins in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            acc      <= '0;
            idx      <= '0;
            o_signal <= '0;
            o_valid  <= 1'b0;
`ifdef FIR_INV_RANGE_CHK_EN
            o_range_err <= 1'b0;
`endif
        end else if (i_flush) begin
            state   <= IDLE;
            acc     <= '0;
            idx     <= '0;
            o_valid <= 1'b0;
`ifdef FIR_INV_RANGE_CHK_EN
            o_range_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        acc   <= i_signal;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_next;
                    if (last_mac) begin
                        idx      <= '0;
                        o_signal <= acc_next[WIDTH-1:0];
                        o_valid  <= 1'b1;
`ifdef FIR_INV_RANGE_CHK_EN
                        // nonzero upper half covers overflow and wrapped-negative
                        o_range_err <= |acc_next[AW-1:WIDTH];
`endif
                        state    <= OUT;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
`ifdef FIR_INV_RANGE_CHK_EN
                        o_range_err <= 1'b0;
`endif
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_inverse.sv
// Self-checking bench for fir_inverse: directed test-plan sequences plus
// randomized samples encoded with the forward FIR and decoded by the DUT.
module tb_fir_inverse;

    localparam int WIDTH = 16;

    logic                clk;
    logic                rst_n;
    logic [2*WIDTH-1:0]  i_signal;
    logic                i_valid;
    logic                o_ready;
    logic [WIDTH-1:0]    o_signal;
    logic                o_valid;
    logic                i_ready;
    logic                i_flush;
`ifdef FIR_INV_RANGE_CHK_EN
    logic                o_range_err;
`endif

    int passes = 0;
    int total  = 0;

    // reference history of recovered samples, index 0 newest
    logic [WIDTH-1:0] mh [0:14];

    fir_inverse #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_signal (i_signal),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .o_signal (o_signal),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .i_flush  (i_flush)
`ifdef FIR_INV_RANGE_CHK_EN
        ,
        .o_range_err (o_range_err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 15; i++) mh[i] = '0;
    endfunction

    function automatic void model_push(input logic [WIDTH-1:0] x);
        for (int i = 14; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = x;
    endfunction

    // y - sum b_k * x[n-k], b_k = k+1, wrapping in 32 bits
    function automatic logic [31:0] model_residual(input logic [31:0] y);
        logic [31:0] r;
        r = y;
        for (int k = 1; k <= 15; k++) r = r - 32'(k + 1) * {16'h0, mh[k-1]};
        return r;
    endfunction

    // forward FIR output for a fresh input x given the model history
    function automatic logic [31:0] model_forward(input logic [WIDTH-1:0] x);
        logic [31:0] y;
        y = {16'h0, x};
        for (int k = 1; k <= 15; k++) y = y + 32'(k + 1) * {16'h0, mh[k-1]};
        return y;
    endfunction

    // offer one sample, measure latency, check output and hold behaviour
    task automatic send(input logic [31:0] y, input int stall, input bit hs,
                        output logic [WIDTH-1:0] got);
        logic [31:0] r;
        int lat;
        check("o_ready_idle", o_ready, 1);
        r = model_residual(y);
        model_push(r[WIDTH-1:0]);
        i_signal = y;
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
        check("o_ready_busy", o_ready, 0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("latency", lat, 15);
        got = o_signal;
        check("o_signal", o_signal, r[WIDTH-1:0]);
`ifdef FIR_INV_RANGE_CHK_EN
        check("o_range_err", o_range_err, (r[31:16] != 16'h0) ? 1 : 0);
`endif
        for (int s = 0; s < stall; s++) begin
            tick();
            check("hold_signal", o_signal, r[WIDTH-1:0]);
            check("hold_valid", o_valid, 1);
            check("hold_no_ready", o_ready, 0);
        end
        if (hs) begin
            i_ready = 1'b1;
            tick();
            i_ready = 1'b0;
            check("post_hs_valid", o_valid, 0);
            check("post_hs_ready", o_ready, 1);
        end
    endtask

    task automatic flush_now();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        model_clear();
    endtask

    task automatic impulse_test();
        logic [WIDTH-1:0] got;
        for (int k = 0; k < 20; k++) begin
            send((k < 16) ? 32'(5 * (k + 1)) : 32'h0, 0, 1'b1, got);
            check("impulse", got, (k == 0) ? 5 : 0);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] x;
        int seen;

        model_clear();
        rst_n    = 1'b0;
        i_signal = '0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_flush  = 1'b0;
        #12;
        check("rst_o_ready", o_ready, 1);
        check("rst_o_valid", o_valid, 0);
        check("rst_o_signal", o_signal, 0);
`ifdef FIR_INV_RANGE_CHK_EN
        check("rst_o_range_err", o_range_err, 0);
`endif
        #10 rst_n = 1'b1;
        tick();

        // impulse
        impulse_test();

        // step: y = 1,3,6,10,15 recovers constant 1
        flush_now();
        for (int k = 1; k <= 5; k++) begin
            send(32'(k * (k + 1) / 2), 0, 1'b1, got);
            check("step", got, 1);
        end

        // backpressure: 5 stalled cycles in OUT, then a back-to-back sample
        send(32'd21, 5, 1'b1, got);
        check("bp_step", got, 1);
        send(32'd28, 0, 1'b1, got);
        check("bp_next", got, 1);

        // flush on MAC cycle 7 of the second step sample
        flush_now();
        send(32'd1, 0, 1'b1, got);
        i_signal = 32'd3;
        i_valid  = 1'b1;
        tick();
        i_valid  = 1'b0;
        repeat (6) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        model_clear();
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_valid === 1'b1) seen++;
            tick();
        end
        check("flush_no_valid", seen, 0);
        check("flush_ready", o_ready, 1);
        send(32'd1, 0, 1'b1, got);
        check("flush_hist_zero", got, 1);

        // a sample offered together with flush is not taken
        i_signal = 32'd99;
        i_valid  = 1'b1;
        i_flush  = 1'b1;
        tick();
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        model_clear();
        check("flush_blocks_accept", o_ready, 1);

        // range: overflow from empty history, then wrapped-negative residual
        send(32'd70000, 1, 1'b1, got);
        check("range_overflow_sig", got, 4464);
        flush_now();
        send(32'd1, 0, 1'b1, got);
        send(32'd0, 0, 1'b1, got);
        check("range_negative_sig", got, 16'hFFFE);

        // randomized: forward-encode random x, decoder must recover it
        flush_now();
        for (int n = 0; n < 24; n++) begin
            x = WIDTH'($urandom_range(0, 65535));
            send(model_forward(x), $urandom_range(0, 3), 1'b1, got);
            check("random_recover", got, x);
        end

        // reset asserted while holding an output
        send(32'd5, 2, 1'b0, got);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_o_valid", o_valid, 0);
        check("midrst_o_ready", o_ready, 1);
        check("midrst_o_signal", o_signal, 0);
        model_clear();
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        impulse_test();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
